// File: rtl/multicycle_control_if.sv
// Bundle of datapath controls, memory handshakes and status for the multicycle LEGv8 controller.
// The controller uses the master modport. The datapath and memory side uses the slave modport.
interface multicycle_control_if #(
  parameter int unsigned CNT_W = 32
);
  logic [10:0]      opcode;
  logic             zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             ir_write;
  logic             dmem_req;
  logic             memread;
  logic             memwrite;
  logic             reg2loc;
  logic             alusrc;
  logic             mem2reg;
  logic             regwrite;
  logic [3:0]       aluop;
  logic [2:0]       signop;
  logic             pc_write;
  logic             pc_sel;
  logic             retire;
  logic             halted;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, zero, imem_ack, dmem_ack,
    output imem_req, ir_write, dmem_req, memread, memwrite, reg2loc, alusrc, mem2reg,
           regwrite, aluop, signop, pc_write, pc_sel, retire, halted, state, instr_count
  );

  modport slave (
    output opcode, zero, imem_ack, dmem_ack,
    input  imem_req, ir_write, dmem_req, memread, memwrite, reg2loc, alusrc, mem2reg,
           regwrite, aluop, signop, pc_write, pc_sel, retire, halted, state, instr_count
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencing controller: FETCH/DECODE/EXEC/MEM/WB walk with memory
// handshakes, a latched instruction class, a retired-instruction counter and an illegal-op trap.
module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input logic                 CLK,
  input logic                 resetl,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    ClsIllegal, ClsLdur, ClsStur, ClsAddReg, ClsSubReg, ClsAndReg, ClsOrrReg,
    ClsAddImm, ClsSubImm, ClsCbz, ClsB, ClsMovz
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d, cls_dec;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic [3:0] f_aluop;
  logic [2:0] f_signop;
  logic       f_alusrc, f_reg2loc;

  // casez picks the first matching arm, which gives the required decode priority.
  always_comb begin
    cls_dec = ClsIllegal;
    casez (bus.opcode)
      11'b??111000010: cls_dec = ClsLdur;
      11'b??111000000: cls_dec = ClsStur;
      11'b?0?01011???: cls_dec = ClsAddReg;
      11'b?1?01011???: cls_dec = ClsSubReg;
      11'b?0001010???: cls_dec = ClsAndReg;
      11'b?0101010???: cls_dec = ClsOrrReg;
      11'b?0?10001???: cls_dec = ClsAddImm;
      11'b?1?10001???: cls_dec = ClsSubImm;
      11'b?011010????: cls_dec = ClsCbz;
      11'b?00101?????: cls_dec = ClsB;
      11'b110100101??: cls_dec = ClsMovz;
      default:         cls_dec = ClsIllegal;
    endcase
  end

  assign cls_d = (state_q == StDecode) ? cls_dec : cls_q;

  always_comb begin
    f_aluop   = 4'b0000;
    f_signop  = 3'b000;
    f_alusrc  = 1'b0;
    f_reg2loc = 1'b0;
    unique case (cls_q)
      ClsLdur:   begin f_aluop = 4'b0010; f_signop = 3'b001; f_alusrc = 1'b1; end
      ClsStur:   begin
        f_aluop = 4'b0010; f_signop = 3'b001; f_alusrc = 1'b1; f_reg2loc = 1'b1;
      end
      ClsAddReg: f_aluop = 4'b0010;
      ClsSubReg: f_aluop = 4'b0110;
      ClsAndReg: f_aluop = 4'b0000;
      ClsOrrReg: f_aluop = 4'b0001;
      ClsAddImm: begin f_aluop = 4'b0010; f_alusrc = 1'b1; end
      ClsSubImm: begin f_aluop = 4'b0110; f_alusrc = 1'b1; end
      ClsCbz:    begin f_aluop = 4'b0111; f_signop = 3'b011; f_reg2loc = 1'b1; end
      ClsB:      f_signop = 3'b010;
      ClsMovz:   begin f_aluop = 4'b0111; f_signop = 3'b100; f_alusrc = 1'b1; end
      default:   ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    retire       = 1'b0;
    bus.imem_req = 1'b0;
    bus.ir_write = 1'b0;
    bus.dmem_req = 1'b0;
    bus.memread  = 1'b0;
    bus.memwrite = 1'b0;
    bus.reg2loc  = 1'b0;
    bus.alusrc   = 1'b0;
    bus.mem2reg  = 1'b0;
    bus.regwrite = 1'b0;
    bus.aluop    = 4'b0000;
    bus.signop   = 3'b000;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.halted   = 1'b0;
    // Class fields are visible only in the states that use the latched class.
    if (state_q == StExec || state_q == StMem || state_q == StWb) begin
      bus.aluop   = f_aluop;
      bus.signop  = f_signop;
      bus.alusrc  = f_alusrc;
      bus.reg2loc = f_reg2loc;
    end
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch: begin
        bus.imem_req = 1'b1;
        bus.ir_write = bus.imem_ack;
        if (bus.imem_ack) state_d = StDecode;
      end
      StDecode: state_d = (cls_dec == ClsIllegal) ? StHalt : StExec;
      StExec: begin
        unique case (cls_q)
          ClsLdur, ClsStur: state_d = StMem;
          ClsCbz: begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = bus.zero;
            retire       = 1'b1;
            state_d      = StFetch;
          end
          ClsB: begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = 1'b1;
            retire       = 1'b1;
            state_d      = StFetch;
          end
          default: state_d = StWb;
        endcase
      end
      StMem: begin
        bus.dmem_req = 1'b1;
        bus.memread  = (cls_q == ClsLdur);
        bus.memwrite = (cls_q == ClsStur);
        if (bus.dmem_ack) begin
          if (cls_q == ClsStur) begin
            bus.pc_write = 1'b1;
            retire       = 1'b1;
            state_d      = StFetch;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        bus.regwrite = 1'b1;
        bus.mem2reg  = (cls_q == ClsLdur);
        bus.pc_write = 1'b1;
        retire       = 1'b1;
        state_d      = StFetch;
      end
      StHalt:   bus.halted = 1'b1;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= StIdle;
      cls_q   <= ClsIllegal;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.retire      = retire;
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control (CNT_W=4): the driver queues expected per-cycle
// snapshots, and a negedge monitor pops and compares them against the DUT outputs.
module tb_multicycle_control;

  localparam int unsigned CW = 4;

  localparam int C_ILL = 0, C_LDUR = 1, C_STUR = 2, C_ADDR = 3, C_SUBR = 4, C_ANDR = 5,
                 C_ORRR = 6, C_ADDI = 7, C_SUBI = 8, C_CBZ = 9, C_B = 10, C_MOVZ = 11;

  typedef struct packed {
    logic [2:0]    state;
    logic          imem_req, ir_write, dmem_req, memread, memwrite;
    logic          reg2loc, alusrc, mem2reg, regwrite;
    logic [3:0]    aluop;
    logic [2:0]    signop;
    logic          pc_write, pc_sel, retire, halted;
    logic [CW-1:0] cnt;
  } snap_t;

  typedef struct {
    snap_t v;
    string name;
  } item_t;

  logic CLK = 1'b0;
  logic resetl;
  multicycle_control_if #(.CNT_W(CW)) bus ();

  multicycle_control #(.CNT_W(CW)) dut (
    .CLK   (CLK),
    .resetl(resetl),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  item_t          sb[$];
  int             n_checks = 0;
  int             n_fail   = 0;
  logic [CW-1:0]  cnt      = '0;

  // Monitor: one snapshot comparison per cycle with an outstanding expectation.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      item_t it;
      snap_t act;
      it  = sb.pop_front();
      act = {bus.state, bus.imem_req, bus.ir_write, bus.dmem_req, bus.memread, bus.memwrite,
             bus.reg2loc, bus.alusrc, bus.mem2reg, bus.regwrite, bus.aluop, bus.signop,
             bus.pc_write, bus.pc_sel, bus.retire, bus.halted, bus.instr_count};
      n_checks++;
      if (act !== it.v) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (st,ireq,irw,dreq,mr,mw,r2l,asrc,m2r,rw,aluop,signop,pcw,pcsel,ret,halt,cnt)",
                 it.name, act, it.v);
      end
    end
  end

  function automatic snap_t base(input logic [2:0] st);
    snap_t s;
    s       = '0;
    s.state = st;
    s.cnt   = cnt;
    return s;
  endfunction

  function automatic snap_t with_fields(input snap_t s0, input int cls);
    snap_t s;
    s = s0;
    case (cls)
      C_LDUR: begin s.aluop = 4'b0010; s.signop = 3'b001; s.alusrc = 1; end
      C_STUR: begin s.aluop = 4'b0010; s.signop = 3'b001; s.alusrc = 1; s.reg2loc = 1; end
      C_ADDR: s.aluop = 4'b0010;
      C_SUBR: s.aluop = 4'b0110;
      C_ANDR: s.aluop = 4'b0000;
      C_ORRR: s.aluop = 4'b0001;
      C_ADDI: begin s.aluop = 4'b0010; s.alusrc = 1; end
      C_SUBI: begin s.aluop = 4'b0110; s.alusrc = 1; end
      C_CBZ:  begin s.aluop = 4'b0111; s.signop = 3'b011; s.reg2loc = 1; end
      C_B:    s.signop = 3'b010;
      C_MOVZ: begin s.aluop = 4'b0111; s.signop = 3'b100; s.alusrc = 1; end
      default: ;
    endcase
    return s;
  endfunction

  task automatic step(input snap_t e, input string name);
    item_t it;
    it.v    = e;
    it.name = name;
    sb.push_back(it);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_fetch(input int waits);
    snap_t s;
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      s = base(3'd1); s.imem_req = 1;
      step(s, "fetch_wait");
    end
    bus.imem_ack = 1'b1;
    s = base(3'd1); s.imem_req = 1; s.ir_write = 1;
    step(s, "fetch_ack");
  endtask

  task automatic do_decode(input logic [10:0] op);
    bus.opcode = op;
    step(base(3'd2), "decode");
    bus.opcode = 11'h000;  // later states must rely on the latched class
  endtask

  task automatic do_exec(input int cls, input logic z, input string name);
    snap_t s;
    bus.zero = z;
    s = with_fields(base(3'd3), cls);
    if (cls == C_CBZ) begin s.pc_write = 1; s.pc_sel = z; s.retire = 1; end
    if (cls == C_B)   begin s.pc_write = 1; s.pc_sel = 1; s.retire = 1; end
    step(s, name);
    if (cls == C_CBZ || cls == C_B) cnt = cnt + 1'b1;
    bus.zero = ~z;
  endtask

  task automatic do_mem_cycle(input int cls, input logic ack);
    snap_t s;
    bus.dmem_ack = ack;
    s = with_fields(base(3'd4), cls);
    s.dmem_req = 1;
    s.memread  = (cls == C_LDUR);
    s.memwrite = (cls == C_STUR);
    if (cls == C_STUR && ack) begin s.pc_write = 1; s.retire = 1; end
    step(s, ack ? "mem_ack" : "mem_wait");
    if (cls == C_STUR && ack) cnt = cnt + 1'b1;
    bus.dmem_ack = 1'b1;
  endtask

  task automatic do_wb(input int cls, input string name);
    snap_t s;
    s = with_fields(base(3'd5), cls);
    s.regwrite = 1;
    s.mem2reg  = (cls == C_LDUR);
    s.pc_write = 1;
    s.retire   = 1;
    step(s, name);
    cnt = cnt + 1'b1;
  endtask

  task automatic run_instr(input logic [10:0] op, input int cls, input int fwait,
                           input int mwait, input logic z, input string name);
    do_fetch(fwait);
    do_decode(op);
    do_exec(cls, z, name);
    if (cls == C_LDUR || cls == C_STUR) begin
      for (int i = 0; i < mwait; i++) do_mem_cycle(cls, 1'b0);
      do_mem_cycle(cls, 1'b1);
      if (cls == C_STUR) return;
    end
    if (cls != C_CBZ && cls != C_B) do_wb(cls, name);
  endtask

  initial begin
    snap_t h;
    resetl       = 1'b0;
    bus.opcode   = '0;
    bus.zero     = 1'b0;
    bus.imem_ack = 1'b1;
    bus.dmem_ack = 1'b1;
    @(posedge CLK);
    #1;
    step(base(3'd0), "reset_idle");
    step(base(3'd0), "reset_idle_hold");
    resetl = 1'b1;
    step(base(3'd0), "idle_after_release");

    run_instr(11'b10001011000, C_ADDR, 0, 0, 1'b0, "addreg");
    run_instr(11'b11111000010, C_LDUR, 0, 3, 1'b0, "ldur");
    run_instr(11'b11010001000, C_SUBI, 2, 0, 1'b0, "subimm");
    run_instr(11'b10110100101, C_CBZ,  0, 0, 1'b1, "cbz_taken");
    run_instr(11'b10110100101, C_CBZ,  0, 0, 1'b0, "cbz_not_taken");
    run_instr(11'b11111000000, C_STUR, 0, 1, 1'b0, "stur");
    run_instr(11'b10001010000, C_ANDR, 0, 0, 1'b0, "andreg");
    run_instr(11'b10101010000, C_ORRR, 0, 0, 1'b0, "orrreg");
    run_instr(11'b11001011000, C_SUBR, 0, 0, 1'b0, "subreg");
    run_instr(11'b10010001000, C_ADDI, 0, 0, 1'b0, "addimm");
    run_instr(11'b11010010100, C_MOVZ, 0, 0, 1'b0, "movz");
    for (int i = 0; i < 17; i++) run_instr(11'b00010100000, C_B, 0, 0, 1'b0, "b_wrap");

    // Reset in the middle of a stalled STUR data access.
    do_fetch(0);
    do_decode(11'b11111000000);
    do_exec(C_STUR, 1'b0, "stur_exec");
    do_mem_cycle(C_STUR, 1'b0);
    bus.dmem_ack = 1'b0;
    resetl = 1'b0;
    cnt    = '0;
    #1;
    step(base(3'd0), "reset_mid_mem");
    step(base(3'd0), "reset_mid_mem_hold");
    resetl = 1'b1;
    bus.dmem_ack = 1'b1;
    step(base(3'd0), "idle_after_rerelease");
    run_instr(11'b10001011000, C_ADDR, 0, 0, 1'b0, "addreg_restart");

    // Illegal opcode traps and stays trapped.
    do_fetch(0);
    do_decode(11'b00000000000);
    for (int i = 0; i < 20; i++) begin
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
      bus.zero     = i[0];
      bus.opcode   = 11'($urandom);
      h = base(3'd6);
      h.halted = 1;
      step(h, "halt");
    end

    repeat (2) @(posedge CLK);
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the multicycle LEGv8 datapath. It walks each instruction through fetch, decode, execute, memory and write-back states. It drives the same datapath control fields as the single-cycle decoder (reg2loc, alusrc, mem2reg, regwrite, memread, memwrite, aluop, signop), plus PC and IR enables, and request/acknowledge handshakes to variable-latency instruction and data memories. It also counts retired instructions and halts on an undecodable opcode.

## Interface
- CNT_W, 32, width of retired-instruction counter
- CLK  in  1  clock, rising-edge
- resetl  in  1  reset, asynchronous, active-low
- opcode  in  11  instruction[31:21] from IR; sampled in DECODE only
- zero  in  1  ALU zero flag; sampled in EXEC for CBZ
- imem_ack  in  1  instruction memory data valid this cycle
- dmem_ack  in  1  data memory access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_write  out  1  IR load enable
- dmem_req  out  1  data memory request
- memread / memwrite  out  1 each  data memory direction
- reg2loc, alusrc, mem2reg, regwrite  out  1 each  datapath selects/enables
- aluop  out  4  ALU operation
- signop  out  3  sign-extender mode
- pc_write  out  1  PC load enable
- pc_sel  out  1  0 = PC+4, 1 = PC + sign-extended offset
- retire  out  1  one-cycle pulse per completed instruction
- halted  out  1  illegal opcode trapped
- state  out  3  current state encoding
- instr_count  out  CNT_W  retired-instruction count

## Operation
- Decode classes, checked in priority order; ? = don't care:
  - LDUR ??111000010
  - STUR ??111000000
  - ADDREG ?0?01011???
  - SUBREG ?1?01011???
  - ANDREG ?0001010???
  - ORRREG ?0101010???
  - ADDIMM ?0?10001???
  - SUBIMM ?1?10001???
  - CBZ ?011010????
  - B ?00101?????
  - MOVZ 110100101??
  - anything else is ILLEGAL
- Per class: aluop / signop / alusrc / reg2loc:
  - LDUR, STUR: 0010 / 001 / 1; reg2loc 1 for STUR, 0 for LDUR
  - ADDREG: 0010 / 000 / 0 / 0
  - SUBREG: 0110 / 000 / 0 / 0
  - ANDREG: 0000 / 000 / 0 / 0
  - ORRREG: 0001 / 000 / 0 / 0
  - ADDIMM: 0010 / 000 / 1 / 0
  - SUBIMM: 0110 / 000 / 1 / 0
  - CBZ: 0111 / 011 / 0 / 1
  - B: 0000 / 010 / 0 / 0
  - MOVZ: 0111 / 100 / 1 / 0
- A 4-bit class register is loaded from opcode on the DECODE cycle. All EXEC, MEM and WB fields derive from this register, never from live opcode.
- States and encodings:
  - IDLE=0: all outputs 0. Goes to FETCH unconditionally.
  - FETCH=1: imem_req=1 and ir_write=imem_ack. Stays in FETCH until imem_ack, then DECODE.
  - DECODE=2: loads the class register. ILLEGAL goes to HALT; otherwise EXEC.
  - EXEC=3: class fields driven.
    - LDUR/STUR go to MEM.
    - R-type, IMM and MOVZ go to WB.
    - CBZ: pc_write=1, pc_sel=zero, retire=1, then FETCH.
    - B: pc_write=1, pc_sel=1, retire=1, then FETCH.
  - MEM=4: class fields held; dmem_req=1; memread=1 for LDUR, memwrite=1 for STUR. Stays in MEM until dmem_ack.
    - LDUR on ack goes to WB.
    - STUR on ack: pc_write=1, pc_sel=0, retire=1, then FETCH.
  - WB=5: class fields held; regwrite=1, mem2reg=1 only for LDUR; pc_write=1, pc_sel=0, retire=1, then FETCH.
  - HALT=6: halted=1, all other control outputs 0. Stays in HALT until reset.
- Outputs are combinational from state, class register, zero and acks. Any field not listed for a state is 0; the block never drives x.
- instr_count increments on every retire cycle and wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (resetl=0, any cycle, including mid-handshake): state=IDLE and instr_count=0 immediately. Every output is 0, including imem_req and dmem_req.
- First rising CLK edge with resetl=1: IDLE→FETCH. imem_req rises in the cycle after reset release.
- Cycles per instruction with same-cycle acks: R/IMM/MOVZ 4, LDUR 5, STUR 4, CBZ/B 3. Each wait cycle in FETCH or MEM adds 1.
- Handshakes: the controller holds imem_req/dmem_req high until the corresponding ack is sampled high at a rising edge. The request drops in the following state. Acks outside FETCH/MEM are ignored.
- zero is used only in the EXEC cycle of CBZ.
- retire and pc_write coincide, exactly one cycle per instruction. The next FETCH follows immediately.
- HALT is absorbing: acks, zero and opcode changes have no effect; instr_count freezes.

## Test plan
- Reset then ADDREG (opcode 10001011000), imem_ack high, dmem_ack high:
  - state sequence 0,1,2,3,5,1.
  - In WB: regwrite=1, aluop=0010, pc_sel=0, pc_write=1.
  - instr_count=1.
- LDUR (11111000010) with dmem_ack delayed 3 cycles:
  - MEM lasts 4 cycles with dmem_req=memread=1 throughout.
  - WB has mem2reg=1, regwrite=1; total 8 cycles.
- CBZ (10110100xxx):
  - zero=1 → EXEC drives pc_write=1, pc_sel=1, reg2loc=1, signop=011.
  - zero=0 → pc_sel=0; no MEM/WB visited.
- Illegal opcode 00000000000:
  - DECODE→HALT, halted=1.
  - imem_req stays 0 for 20 cycles despite acks.
  - instr_count unchanged.
- Assert resetl=0 mid-MEM of STUR with dmem_req=1:
  - dmem_req and memwrite drop in the same cycle; state=0, instr_count=0.
  - Operation restarts at FETCH after release.
- Run 2^CNT_W B instructions (CNT_W=4 build): instr_count wraps 15→0 on the 16th retire.
